// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and helpers for the LEGv8 instruction fetch front-end.
package instruction_fetch_unit_pkg;

   localparam int DEFAULT_PC_STEP  = 4;
   localparam int DEFAULT_RESET_PC = 0;
   localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

   // Queue pointer width; a one-entry queue still needs a one-bit pointer.
   function automatic int ptrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// First-word fall-through prefetch queue with push, pop, flush and occupancy count.
// The head word reads as zero whenever the queue is empty.
module instruction_fetch_unit_fetch_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          pushData,
   output logic [WIDTH-1:0]          headData,
   output logic                      headValid,
   output logic [ptrWidth(DEPTH):0]  count
);

   localparam int PW = ptrWidth(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wrPtr] <= pushData;
   end

   assign headValid = (count != '0);
   assign headData  = headValid ? mem[rdPtr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch front-end: owns the PC, issues credit-limited reads to a 1-cycle
// instruction memory and hands buffered {instruction, PC} pairs to decode.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4,
   parameter int PC_STEP     = DEFAULT_PC_STEP,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      imemReq,
   output logic [ADDR_WIDTH-1:0]     imemAddr,
   input  logic [INSTR_WIDTH-1:0]    imemData,
   input  logic                      redirectValid,
   input  logic [ADDR_WIDTH-1:0]     redirectTarget,
   output logic                      instrValid,
   input  logic                      instrReady,
   output logic [INSTR_WIDTH-1:0]    instruction,
   output logic [ADDR_WIDTH-1:0]     instrPC,
   output logic [ptrWidth(DEPTH):0]  queueCount
);

   logic [ADDR_WIDTH-1:0]             fetchPC;
   logic [ADDR_WIDTH-1:0]             reqPC;
   logic                              inFlight;
   logic                              credit;
   logic                              pushEn;
   logic                              popEn;
   logic [INSTR_WIDTH+ADDR_WIDTH-1:0] headData;

   // A request is only issued when its word is guaranteed a queue slot.
   assign credit   = (32'(queueCount) + 32'(inFlight)) < 32'(DEPTH);
   assign imemReq  = !reset && !redirectValid && credit;
   assign imemAddr = fetchPC;

   // With single-cycle memory latency the only stale response is the one
   // returning in the redirect cycle itself, so gating the push discards it.
   assign pushEn = inFlight && !redirectValid;

   // Decode handshake: a word transfers on every rising edge where instrValid
   // and instrReady are both high; instrValid never depends on instrReady and
   // the head stays stable until it is taken or flushed by a redirect.
   assign popEn = instrValid && instrReady;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetchPC  <= RESET_PC;
         reqPC    <= RESET_PC;
         inFlight <= 1'b0;
      end else begin
         inFlight <= imemReq;
         if (redirectValid) begin
            fetchPC <= redirectTarget;
         end else if (imemReq) begin
            fetchPC <= fetchPC + ADDR_WIDTH'(PC_STEP);
            reqPC   <= fetchPC;
         end
      end
   end

   instruction_fetch_unit_fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_WIDTH + ADDR_WIDTH)
   ) fetchQueue (
      .clock     (clock),
      .reset     (reset),
      .push      (pushEn),
      .pop       (popEn),
      .flush     (redirectValid),
      .pushData  ({imemData, reqPC}),
      .headData  (headData),
      .headValid (instrValid),
      .count     (queueCount)
   );

   assign instruction = headData[INSTR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
   assign instrPC     = headData[ADDR_WIDTH-1:0];

endmodule
